// File: rtl/proc_pkg.sv
// Shared constants for the 9-bit processor control sequencer.
// Holds opcodes, ALU codes, bus select codes and the sequencer state enum.
package proc_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_POP = 3'b100;

    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_POP  = 2'b11;

    localparam logic [3:0] SEL_G   = 4'd8;
    localparam logic [3:0] SEL_DIN = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3
    } state_t;

endpackage

// File: rtl/proc_control_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// Carries run/din in and all load strobes, ALU op, bus select, done, busy out.
interface proc_control_if #(
    parameter int DATA_W = 9,
    parameter int NREG   = 8
);
    logic              run;
    logic [DATA_W-1:0] din;
    logic              ir_load;
    logic [NREG-1:0]   r_load;
    logic              a_load;
    logic              g_load;
    logic [1:0]        alu_op;
    logic [3:0]        bus_sel;
    logic              done;
    logic              busy;

    modport master (
        input  run, din,
        output ir_load, r_load, a_load, g_load,
        output alu_op, bus_sel, done, busy
    );

    modport slave (
        output run, din,
        input  ir_load, r_load, a_load, g_load,
        input  alu_op, bus_sel, done, busy
    );
endinterface

// File: rtl/reg_onehot_dec.sv
// 3-to-8 one-hot decoder with enable, drives the register-file write enables.
// Ports: en (enable), sel (register index), onehot (decoded enables).
module reg_onehot_dec #(
    parameter int N = 8
) (
    input  logic         en,
    input  logic [2:0]   sel,
    output logic [N-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end
endmodule

// File: rtl/proc_control.sv
// Multi-cycle control sequencer: captures an instruction, walks T1..T3.
// Ports: clk, rst_n (async active-low), bus (master modport of control bundle).
module proc_control
    import proc_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int NREG   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    proc_control_if.master bus
);
    state_t            state, state_n;
    logic [DATA_W-1:0] ir;
    logic [2:0]        op, rx, ry;
    logic              r_en;

    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && bus.run) ir <= bus.din;
        end
    end

    always_comb begin
        state_n     = state;
        r_en        = 1'b0;
        bus.ir_load = 1'b0;
        bus.a_load  = 1'b0;
        bus.g_load  = 1'b0;
        bus.alu_op  = ALU_NONE;
        bus.bus_sel = SEL_DIN;
        bus.done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.ir_load = bus.run;
                if (bus.run) state_n = S_T1;
            end
            S_T1: begin
                case (op)
                    OP_MV: begin
                        bus.bus_sel = {1'b0, ry};
                        r_en        = 1'b1;
                        bus.done    = 1'b1;
                        state_n     = S_IDLE;
                    end
                    OP_MVI: begin
                        r_en     = 1'b1;
                        bus.done = 1'b1;
                        state_n  = S_IDLE;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.bus_sel = {1'b0, rx};
                        bus.a_load  = 1'b1;
                        state_n     = S_T2;
                    end
                    OP_POP: begin
                        bus.bus_sel = {1'b0, ry};
                        bus.alu_op  = ALU_POP;
                        bus.g_load  = 1'b1;
                        state_n     = S_T2;
                    end
                    default: begin
                        bus.done = 1'b1;
                        state_n  = S_IDLE;
                    end
                endcase
            end
            S_T2: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    bus.bus_sel = {1'b0, ry};
                    bus.alu_op  = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
                    bus.g_load  = 1'b1;
                    state_n     = S_T3;
                end else begin
                    // only pop reaches T2 otherwise
                    bus.bus_sel = SEL_G;
                    r_en        = 1'b1;
                    bus.done    = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_T3: begin
                bus.bus_sel = SEL_G;
                r_en        = 1'b1;
                bus.done    = 1'b1;
                state_n     = S_IDLE;
            end
        endcase
    end

    assign bus.busy = (state != S_IDLE);

    reg_onehot_dec #(.N(NREG)) u_dec (
        .en     (r_en),
        .sel    (rx),
        .onehot (bus.r_load)
    );
endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: directed steps plus random traffic.
// Expected outputs come from a per-instruction micro-step queue model.
module tb_proc_control;
    logic clk;
    logic rst_n;

    proc_control_if #(.DATA_W(9), .NREG(8)) bif ();

    proc_control #(.DATA_W(9), .NREG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int obs_done;
    int exp_done;
    logic [18:0] expq[$];

    function automatic logic [18:0] mk(
        logic il, logic [7:0] rl, logic a, logic g,
        logic [1:0] alu, logic [3:0] bs, logic dn, logic by
    );
        return {il, rl, a, g, alu, bs, dn, by};
    endfunction

    function automatic logic [18:0] observed();
        return {bif.ir_load, bif.r_load, bif.a_load, bif.g_load,
                bif.alu_op, bif.bus_sel, bif.done, bif.busy};
    endfunction

    task automatic chk(input string tag, input logic [18:0] obs,
                       input logic [18:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected cycles (T1 onward) for one instruction word.
    task automatic push_instr(input logic [8:0] w);
        logic [2:0] op, rx, ry;
        logic [7:0] one, rl;
        logic [3:0] bx, by;
        op = w[8:6];
        rx = w[5:3];
        ry = w[2:0];
        one = 8'd1;
        rl = one << rx;
        bx = {1'b0, rx};
        by = {1'b0, ry};
        case (op)
            3'd0: expq.push_back(mk(0, rl, 0, 0, 2'd0, by, 1, 1));
            3'd1: expq.push_back(mk(0, rl, 0, 0, 2'd0, 4'd9, 1, 1));
            3'd2, 3'd3: begin
                expq.push_back(mk(0, 8'd0, 1, 0, 2'd0, bx, 0, 1));
                expq.push_back(mk(0, 8'd0, 0, 1,
                                  (op == 3'd2) ? 2'd1 : 2'd2, by, 0, 1));
                expq.push_back(mk(0, rl, 0, 0, 2'd0, 4'd8, 1, 1));
            end
            3'd4: begin
                expq.push_back(mk(0, 8'd0, 0, 1, 2'd3, by, 0, 1));
                expq.push_back(mk(0, rl, 0, 0, 2'd0, 4'd8, 1, 1));
            end
            default: expq.push_back(mk(0, 8'd0, 0, 0, 2'd0, 4'd9, 1, 1));
        endcase
    endtask

    // One clock: drive inputs, check model vs DUT, advance the edge.
    task automatic cyc(input string tag, input logic r, input logic [8:0] d);
        logic [18:0] e;
        bif.run = r;
        bif.din = d;
        #3;
        if (expq.size() == 0) begin
            e = mk(r, 8'd0, 0, 0, 2'd0, 4'd9, 0, 0);
            if (r) push_instr(d);
        end else begin
            e = expq.pop_front();
        end
        if (e[1]) exp_done++;
        if (bif.done === 1'b1) obs_done++;
        chk(tag, observed(), e);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset landing between clock edges.
    task automatic async_reset(input string tag);
        bif.run = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        expq.delete();
        chk({tag, "_assert"}, observed(),
            mk(0, 8'd0, 0, 0, 2'd0, 4'd9, 0, 0));
        @(posedge clk);
        #1;
        bif.run = 1'b1;
        #1;
        chk({tag, "_held"}, observed(),
            mk(1, 8'd0, 0, 0, 2'd0, 4'd9, 0, 0));
        bif.run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [8:0] w;
        logic r;
        checks = 0;
        errors = 0;
        obs_done = 0;
        exp_done = 0;
        bif.run = 1'b0;
        bif.din = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", observed(), mk(0, 8'd0, 0, 0, 2'd0, 4'd9, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // add R0,R7 aborted by reset in T2, then mv R1,R2
        cyc("add_abort_idle", 1, 9'b010_000_111);
        cyc("add_abort_t1", 0, 9'h000);
        bif.run = 1'b0;
        #2;
        chk("add_abort_t2", observed(), mk(0, 8'd0, 0, 1, 2'd1, 4'd7, 0, 1));
        async_reset("rst_mid_add");
        @(posedge clk);
        #1;
        cyc("mv_idle", 1, 9'b000_001_010);
        cyc("mv_t1", 0, 9'h000);
        cyc("mv_gap", 0, 9'h000);

        // mvi R5 with immediate on din in T1
        cyc("mvi_idle", 1, 9'b001_101_000);
        cyc("mvi_t1", 0, 9'h0AB);

        // full add R0,R7
        cyc("add_idle", 1, 9'b010_000_111);
        cyc("add_t1", 0, 9'h000);
        cyc("add_t2", 0, 9'h000);
        cyc("add_t3", 0, 9'h000);
        cyc("add_after", 0, 9'h000);

        // sub R4,R4 then pop R2,R6 with run held high
        cyc("sub_idle", 1, 9'b011_100_100);
        cyc("sub_t1", 1, 9'b100_010_110);
        cyc("sub_t2", 1, 9'b100_010_110);
        cyc("sub_t3", 1, 9'b100_010_110);
        cyc("pop_idle", 1, 9'b100_010_110);
        cyc("pop_t1", 0, 9'h000);
        cyc("pop_t2", 0, 9'h000);

        // run pulsed in T2 of add R3,R3 with a different word on din
        cyc("addrun_idle", 1, 9'b010_011_011);
        cyc("addrun_t1", 0, 9'h000);
        cyc("addrun_t2", 1, 9'b000_110_001);
        cyc("addrun_t3", 0, 9'h000);
        cyc("addrun_after", 0, 9'h000);

        // opcode 111 is a NOP
        cyc("nop_idle", 1, 9'b111_010_001);
        cyc("nop_t1", 0, 9'h000);
        cyc("nop_after", 0, 9'h000);

        // random traffic with occasional mid-instruction resets
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) != 0);
            w = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 60) == 0) async_reset("rand_rst");
            else cyc("random", r, w);
        end
        bif.run = 1'b0;
        for (int i = 0; i < 4; i++) cyc("drain", 0, 9'h000);

        checks++;
        assert (obs_done == exp_done) else begin
            errors++;
            $error("FAIL done_count observed=%0d expected=%0d",
                   obs_done, exp_done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
